// File: rtl/pwm_duty_meter_x100.sv
// PWM duty-cycle meter: samples a PWM line on a 2^Conf strobe, reports duty 0..100
// per 100-sample frame along with a multi-edge error flag and a two-frame stability flag.
module pwm_duty_meter_x100 (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       pwm_in,
    input  logic [2:0] Conf,
    output logic [6:0] npwm,
    output logic       valid,
    output logic       err,
    output logic       stable
);
    logic       r_s1;
    logic       r_s2;
    logic [6:0] r_div;
    logic [6:0] r_tick_cnt;
    logic [6:0] r_high_cnt;
    logic [1:0] r_edge_cnt;
    logic       r_prev;
    logic       r_seeded;
    logic       r_have_prev;
    logic [6:0] r_npwm;
    logic       r_valid;
    logic       r_err;
    logic       r_stable;

    logic [7:0] w_mask_wide;
    logic [6:0] w_mask;
    logic       w_stb;
    logic       w_edge_now;
    logic       w_frame_end;
    logic [6:0] w_npwm_new;
    logic [2:0] w_edge_sum;
    logic       w_err_new;
    logic       w_stable_new;

    assign w_mask_wide  = (8'd1 << Conf) - 8'd1;
    assign w_mask       = w_mask_wide[6:0];
    assign w_stb        = ena && ((r_div & w_mask) == w_mask);
    // The sample taken on this strobe is r_s2; the first one after enable only seeds r_prev.
    assign w_edge_now   = r_seeded && r_s2 && !r_prev;
    assign w_frame_end  = w_stb && (r_tick_cnt == 7'd99);
    assign w_npwm_new   = r_high_cnt + {6'd0, r_s2};
    assign w_edge_sum   = {1'b0, r_edge_cnt} + {2'b00, w_edge_now};
    assign w_err_new    = (w_edge_sum >= 3'd2);
    assign w_stable_new = (w_npwm_new == r_npwm) && !w_err_new && !r_err && r_have_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= pwm_in;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= 7'd0;
        end else if (!ena) begin
            r_div <= 7'd0;
        end else begin
            r_div <= r_div + 7'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick_cnt  <= 7'd0;
            r_high_cnt  <= 7'd0;
            r_edge_cnt  <= 2'd0;
            r_prev      <= 1'b0;
            r_seeded    <= 1'b0;
            r_have_prev <= 1'b0;
        end else if (!ena) begin
            r_tick_cnt  <= 7'd0;
            r_high_cnt  <= 7'd0;
            r_edge_cnt  <= 2'd0;
            r_prev      <= 1'b0;
            r_seeded    <= 1'b0;
            r_have_prev <= 1'b0;
        end else if (w_stb) begin
            r_prev   <= r_s2;
            r_seeded <= 1'b1;
            if (w_frame_end) begin
                r_tick_cnt  <= 7'd0;
                r_high_cnt  <= 7'd0;
                r_edge_cnt  <= 2'd0;
                r_have_prev <= 1'b1;
            end else begin
                r_tick_cnt <= r_tick_cnt + 7'd1;
                r_high_cnt <= w_npwm_new;
                r_edge_cnt <= w_err_new ? 2'd2 : w_edge_sum[1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_npwm   <= 7'd0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_stable <= 1'b0;
        end else begin
            r_valid <= w_frame_end;
            if (w_frame_end) begin
                r_npwm   <= w_npwm_new;
                r_err    <= w_err_new;
                r_stable <= w_stable_new;
            end
        end
    end

    assign npwm   = r_npwm;
    assign valid  = r_valid;
    assign err    = r_err;
    assign stable = r_stable;
endmodule
